// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants and helpers for the four-digit BCD display scanner.
// Segment bits are a..g on 0..6, active low.
package bcd_disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIB_W      = 4;
    localparam int WORD_W     = NUM_DIGITS * NIB_W;
    localparam int SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_OFF  = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;

    localparam logic [SEG_W-1:0] SEG_TABLE [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    typedef enum logic {
        HS_EMPTY   = 1'b0,
        HS_PENDING = 1'b1
    } hs_state_t;

    // A digit stays lit if it or any more significant digit is non-zero; digit 0 always lit.
    function automatic logic digit_lit(input logic [WORD_W-1:0] word, input logic [1:0] idx);
        logic lit;
        case (idx)
            2'd0:    lit = 1'b1;
            2'd1:    lit = |word[15:4];
            2'd2:    lit = |word[15:8];
            default: lit = |word[15:12];
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_seg7_encode.sv
// Combinational BCD nibble to active-low seven-segment encoder.
// Non-decimal nibbles encode as a dash and raise invalid.
module seg7_encode
    import bcd_disp_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg_n,
    output logic             invalid
);

    always_comb begin
        seg_n   = SEG_DASH;
        invalid = 1'b1;
        if (nibble < 4'd10) begin
            seg_n   = SEG_TABLE[nibble];
            invalid = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Four-digit multiplexed seven-segment scanner with double-buffered BCD input.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] bcd_in,
    input  logic              bcd_valid,
    output logic              bcd_ready,
    input  logic              blank,
    output logic [SEG_W-1:0]  seg_n,
    output logic [3:0]        an_n,
    output logic              dp_n,
    output logic              bcd_err
);

    // state      | meaning
    // HS_EMPTY   | shadow free, bcd_ready high
    // HS_PENDING | shadow holds a word waiting for the frame boundary

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0]  scan_cnt;
    logic              tick;
    logic [1:0]        digit_idx;
    logic              frame_end;

    hs_state_t         hs_state;
    hs_state_t         hs_next;
    logic              load_shadow;
    logic              promote;

    logic [WORD_W-1:0] active_word;
    logic [WORD_W-1:0] shadow_word;

    logic [NIB_W-1:0]  cur_nib;
    logic [SEG_W-1:0]  enc_seg;
    logic              enc_invalid;
    logic              cur_lit;

    logic [1:0]        slot_idx;
    logic              slot_lit;
    logic [3:0]        an_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (tick) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + CNT_W'(1);
        end
    end

    assign tick      = (scan_cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_end = tick && (digit_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_state  <= HS_EMPTY;
            bcd_ready <= 1'b1;
        end else begin
            hs_state  <= hs_next;
            bcd_ready <= (hs_next == HS_EMPTY);
        end
    end

    always_comb begin
        hs_next = hs_state;
        case (hs_state)
            HS_EMPTY:   if (bcd_valid) hs_next = HS_PENDING;
            HS_PENDING: if (frame_end) hs_next = HS_EMPTY;
            default:    hs_next = HS_EMPTY;
        endcase
    end

    // A word accepted on the boundary tick itself waits for the following boundary.
    always_comb begin
        load_shadow = (hs_state == HS_EMPTY) && bcd_valid;
        promote     = (hs_state == HS_PENDING) && frame_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_word <= '0;
            active_word <= '0;
        end else begin
            if (load_shadow) shadow_word <= bcd_in;
            if (promote)     active_word <= shadow_word;
        end
    end

    assign cur_nib = active_word[{digit_idx, 2'b00} +: NIB_W];

    seg7_encode u_encode (
        .nibble  (cur_nib),
        .seg_n   (enc_seg),
        .invalid (enc_invalid)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign cur_lit = digit_lit(active_word, digit_idx);
`else
    assign cur_lit = 1'b1;
`endif

    // Anodes are re-evaluated every cycle so blank acts within one clock mid-slot.
    always_comb begin
        an_next = 4'hF;
        if (!blank) begin
            if (tick) begin
                if (cur_lit) an_next = ~(4'b0001 << digit_idx);
            end else if (slot_lit) begin
                an_next = ~(4'b0001 << slot_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n    <= SEG_OFF;
            an_n     <= 4'hF;
            dp_n     <= 1'b1;
            bcd_err  <= 1'b0;
            slot_idx <= 2'd0;
            slot_lit <= 1'b0;
        end else begin
            dp_n    <= 1'b1;
            an_n    <= an_next;
            bcd_err <= 1'b0;
            if (tick) begin
                seg_n    <= enc_seg;
                bcd_err  <= enc_invalid && cur_lit && !blank;
                slot_idx <= digit_idx;
                slot_lit <= cur_lit;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner with SCAN_DIV = 4.
// Follows LEADING_ZERO_BLANK_EN the same way as the design build.
module tb_bcd_display_scanner;

    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd_in;
    logic        bcd_valid;
    logic        bcd_ready;
    logic        blank;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        bcd_err;

    int checks   = 0;
    int failures = 0;

    bcd_display_scanner #(.SCAN_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .bcd_valid (bcd_valid),
        .bcd_ready (bcd_ready),
        .blank     (blank),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .dp_n      (dp_n),
        .bcd_err   (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [0:9];
    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic lit_of(input logic [15:0] w, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d == 0) || ((w >> (4 * d)) != 16'h0000);
`else
        return (d >= 0) || (w == w);
`endif
    endfunction

    // Behavioural model: slot timing from the cycle count since reset.
    int          m;
    logic [15:0] m_active, m_shadow;
    logic        m_pending;
    logic        m_have;
    int          m_digit;
    logic        m_lit;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_err;

    always @(posedge clk or negedge rst_n) begin : model
        int          d;
        logic [3:0]  nib;
        logic        lit;
        if (!rst_n) begin
            m         <= 0;
            m_active  <= 16'h0000;
            m_shadow  <= 16'h0000;
            m_pending <= 1'b0;
            m_have    <= 1'b0;
            m_digit   <= 0;
            m_lit     <= 1'b0;
            exp_seg   <= 7'h7F;
            exp_an    <= 4'hF;
            exp_err   <= 1'b0;
        end else begin
            m <= m + 1;
            if ((m % DIV) == DIV - 1) begin
                d   = (m / DIV) % 4;
                nib = m_active[4*d +: 4];
                lit = lit_of(m_active, d);
                exp_seg <= (nib < 4'd10) ? seg_tab[int'(nib)] : 7'b0111111;
                exp_err <= (nib > 4'd9) && lit && !blank;
                exp_an  <= (blank || !lit) ? 4'hF : ~(4'b0001 << d);
                m_have  <= 1'b1;
                m_digit <= d;
                m_lit   <= lit;
            end else begin
                exp_err <= 1'b0;
                exp_an  <= (blank || !m_have || !m_lit) ? 4'hF : ~(4'b0001 << m_digit);
            end
            if (bcd_valid && !m_pending) begin
                m_shadow  <= bcd_in;
                m_pending <= 1'b1;
            end else if (((m % (4 * DIV)) == 4 * DIV - 1) && m_pending) begin
                m_active  <= m_shadow;
                m_pending <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_seg_n", {25'd0, seg_n}, {25'd0, exp_seg});
        chk("cyc_an_n", {28'd0, an_n}, {28'd0, exp_an});
        chk("cyc_bcd_err", {31'd0, bcd_err}, {31'd0, exp_err});
        chk("cyc_bcd_ready", {31'd0, bcd_ready}, {31'd0, !m_pending});
        chk("cyc_dp_n", {31'd0, dp_n}, 32'd1);
    end

    task automatic wait_an(input logic [3:0] v, input string nm);
        int k = 0;
        while (an_n !== v && k < 64) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_an"}, {28'd0, an_n}, {28'd0, v});
    endtask

    task automatic wait_ready(input string nm);
        int k = 0;
        while (bcd_ready !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_ready"}, {31'd0, bcd_ready}, 32'd1);
    endtask

    task automatic offer(input logic [15:0] w);
        bcd_in    = w;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
        chk("ready_drop", {31'd0, bcd_ready}, 32'd0);
    endtask

    initial begin
        int pulses;
        rst_n     = 1'b0;
        bcd_in    = 16'h0000;
        bcd_valid = 1'b0;
        blank     = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_seg", {25'd0, seg_n}, 32'h7F);
        chk("rst_an", {28'd0, an_n}, 32'hF);
        chk("rst_ready", {31'd0, bcd_ready}, 32'd1);
        chk("rst_err", {31'd0, bcd_err}, 32'd0);
        #2 rst_n = 1'b1;

        repeat (3) begin
            @(negedge clk);
            chk("pre_tick_an", {28'd0, an_n}, 32'hF);
        end
        @(negedge clk);
        chk("first_an", {28'd0, an_n}, 32'hE);
        chk("first_seg", {25'd0, seg_n}, {25'd0, 7'b1000000});

        offer(16'h1234);
        wait_ready("w1234");
        wait_an(4'b1110, "d0_1234"); chk("seg_4", {25'd0, seg_n}, {25'd0, 7'b0011001});
        wait_an(4'b1101, "d1_1234"); chk("seg_3", {25'd0, seg_n}, {25'd0, 7'b0110000});
        wait_an(4'b1011, "d2_1234"); chk("seg_2", {25'd0, seg_n}, {25'd0, 7'b0100100});
        wait_an(4'b0111, "d3_1234"); chk("seg_1", {25'd0, seg_n}, {25'd0, 7'b1111001});

        bcd_in    = 16'h5678;
        bcd_valid = 1'b1;
        @(negedge clk);
        chk("ready_drop_5678", {31'd0, bcd_ready}, 32'd0);
        bcd_in = 16'h9999;
        @(negedge clk);
        bcd_valid = 1'b0;
        wait_ready("w5678");
        wait_an(4'b1110, "d0_5678"); chk("seg_8", {25'd0, seg_n}, {25'd0, 7'b0000000});
        wait_an(4'b1101, "d1_5678"); chk("seg_7", {25'd0, seg_n}, {25'd0, 7'b1111000});
        wait_an(4'b1011, "d2_5678"); chk("seg_6", {25'd0, seg_n}, {25'd0, 7'b0000010});
        wait_an(4'b0111, "d3_5678"); chk("seg_5", {25'd0, seg_n}, {25'd0, 7'b0010010});

        offer(16'h00A7);
        wait_ready("w00a7");
        wait_an(4'b1110, "d0_00a7"); chk("seg_7b", {25'd0, seg_n}, {25'd0, 7'b1111000});
        wait_an(4'b1101, "d1_00a7");
        chk("seg_dash", {25'd0, seg_n}, {25'd0, 7'b0111111});
        chk("err_pulse", {31'd0, bcd_err}, 32'd1);
        @(negedge clk);
        chk("err_one_cycle", {31'd0, bcd_err}, 32'd0);
        pulses = 0;
        repeat (4 * DIV) begin
            @(negedge clk);
            if (bcd_err === 1'b1) pulses++;
        end
        chk("err_per_frame", pulses, 32'd1);

        blank = 1'b1;
        @(negedge clk);
        chk("blank_an", {28'd0, an_n}, 32'hF);
        pulses = 0;
        repeat (4 * DIV + 2) begin
            @(negedge clk);
            if (bcd_err === 1'b1) pulses++;
        end
        chk("blank_no_err", pulses, 32'd0);
        blank = 1'b0;
        @(negedge clk);
        chk("unblank_an_lit", {31'd0, (an_n == 4'hF)}, 32'd0);

        offer(16'h0040);
        wait_ready("w0040");
        wait_an(4'b1110, "d0_0040"); chk("seg_0_lo", {25'd0, seg_n}, {25'd0, 7'b1000000});
        wait_an(4'b1101, "d1_0040"); chk("seg_4_lo", {25'd0, seg_n}, {25'd0, 7'b0011001});
`ifdef LEADING_ZERO_BLANK_EN
        repeat (4 * DIV) begin
            @(negedge clk);
            chk("lz_upper_dark", {30'd0, an_n[3:2]}, 32'd3);
        end
`else
        wait_an(4'b1011, "d2_0040"); chk("seg_0_d2", {25'd0, seg_n}, {25'd0, 7'b1000000});
        wait_an(4'b0111, "d3_0040"); chk("seg_0_d3", {25'd0, seg_n}, {25'd0, 7'b1000000});
`endif

        offer(16'h4321);
        wait_ready("w4321");
        wait_an(4'b1101, "d1_4321"); chk("seg_2_4321", {25'd0, seg_n}, {25'd0, 7'b0100100});
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_seg", {25'd0, seg_n}, 32'h7F);
        chk("mid_rst_an", {28'd0, an_n}, 32'hF);
        chk("mid_rst_err", {31'd0, bcd_err}, 32'd0);
        chk("mid_rst_ready", {31'd0, bcd_ready}, 32'd1);
        chk("mid_rst_dp", {31'd0, dp_n}, 32'd1);
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_dark", {28'd0, an_n}, 32'hF);
        end
        @(negedge clk);
        chk("post_rst_an", {28'd0, an_n}, 32'hE);
        chk("post_rst_seg", {25'd0, seg_n}, {25'd0, 7'b1000000});

        repeat (2 * DIV) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
